mux_logic_unit_pipe: RTL and testbench
======================================

// Module: mux_logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit. Every gate function is built from per-bit 2:1 muxes,
//  with operand a as the mux select and b (or a constant) on the data legs.
//  Sits between an upstream producer and a downstream consumer via valid/ready handshakes.
//  2-stage pipeline, full throughput, back-pressure capable, completed-beat counter.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=1)
//  CNT_W    16  width of completed-beat counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      upstream beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_a       in   WIDTH  operand a, used as the per-bit mux select
//  in_b       in   WIDTH  operand b, data leg
//  in_op      in   3      0 AND,1 NAND,2 OR,3 NOR,4 XOR,5 XNOR,6 NOT(a),7 BUF(a)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_y      out  WIDTH  result
//  out_op     out  3      op tag travelling with the result
//  beat_cnt   out  CNT_W  number of completed output handshakes
//  acc_sel    in   1      (MUXLU_ACC_EN only) use the accumulator in place of b
//  acc_clr    in   1      (MUXLU_ACC_EN only) synchronous clear of the accumulator
// BEHAVIOUR
//  Per-bit function, d = b[i]: AND a?d:0; NAND a?~d:1; OR a?1:d; NOR a?0:~d;
//   XOR a?~d:d; XNOR a?d:~d; NOT a?0:1; BUF a?1:0. NOT and BUF ignore d.
//  Reset, asynchronous on rst_n low:
//   - s1_valid, out_valid, out_y, out_op, beat_cnt and acc all clear to 0.
//   - in_ready reads 1 once reset is released.
//   - A beat in flight when reset asserts is discarded. It is neither counted nor output.
//  Stage 1 registers a, b and op.
//  Stage 2 computes the function and registers out_y and out_op.
//  Handshake and advance rules:
//   - s2_adv = !out_valid | out_ready.
//   - in_ready = !s1_valid | s2_adv. This is combinational and never depends on in_valid.
//   - s1 loads on in_valid & in_ready.
//   - On s2_adv: out_valid <= s1_valid, and data loads only if s1_valid.
//  Latency: a beat accepted at edge N is on out_valid/out_y after edge N+1, i.e. 2 cycles through the pipe.
//  Throughput: 1 beat per cycle while out_ready=1. Simultaneous accept and output in one cycle is legal.
//  Stall (out_ready=0 with out_valid=1):
//   - out_y and out_op are held stable.
//   - s1 holds one further beat, then in_ready drops to 0.
//   - No beat is lost or duplicated.
//  When out_ready returns, drain order equals input order.
//  Empty pipe: out_valid=0. out_y keeps its last value; consumers must not sample it.
//  beat_cnt increments on out_valid & out_ready and wraps 2^CNT_W-1 -> 0.
//  Inputs are ignored while in_ready=0, including in_valid, in_a, in_b and in_op.
// CONFIGURATION
//  MUXLU_ACC_EN defined:
//   - Ports acc_sel and acc_clr exist, plus an internal WIDTH-bit register acc.
//   - acc_sel is captured with the beat in s1.
//   - At the s2 load, d = acc if the captured acc_sel=1, otherwise d = b.
//   - acc <= result on every s2 load, so acc tracks the last result.
//   - acc_clr forces acc to 0 and has priority over a same-cycle update.
//   - The beat loading in that cycle still uses the old acc.
//  MUXLU_ACC_EN undefined: no acc_sel/acc_clr ports, no acc register; d = b always.
// TESTING (WIDTH=8)
//  Full op sweep:
//   - Stimulus: a=8'hF0, b=8'hCC, ops 0..7 back-to-back, out_ready=1.
//   - Expect y = C0,3F,FC,03,3C,C3,0F,F0, each 2 cycles after accept.
//  Back-pressure:
//   - Stimulus: 4 beats, out_ready=0 for 5 cycles.
//   - Expect in_ready=0 after 2 accepts and out_y held.
//   - On release, all 4 beats appear in order and beat_cnt=4.
//  Mid-flight reset:
//   - Stimulus: rst_n pulled low while 2 beats are in flight.
//   - Expect out_valid=0, beat_cnt=0 and in_ready=1 after release. Neither beat appears.
//  Counter wrap:
//   - Stimulus: CNT_W=4, 17 beats.
//   - Expect beat_cnt=1.
//  Accumulator (MUXLU_ACC_EN):
//   - acc_clr, then beat op=OR b=8'h0F -> y=0F.
//   - Then op=XOR a=8'hFF acc_sel=1 -> y=F0.
//  Accumulator clear priority: acc_clr asserted with an s2 load -> acc=0 on the next cycle.

Source files
------------

// File: rtl/mux_logic_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// mux_logic_unit_pipe_if
// Handshake/bus bundle for mux_logic_unit_pipe.
//   Upstream side  : in_valid, in_ready, in_a, in_b, in_op
//   Downstream side: out_valid, out_ready, out_y, out_op
//   Status         : beat_cnt (completed output handshakes)
//   Optional       : acc_sel, acc_clr (present only when MUXLU_ACC_EN is defined)
// Modports:
//   slave  - the logic unit itself
//   master - the environment (producer + consumer) driving the unit
// -----------------------------------------------------------------------------
interface mux_logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [2:0]       out_op;
    logic [CNT_W-1:0] beat_cnt;
`ifdef MUXLU_ACC_EN
    logic             acc_sel;
    logic             acc_clr;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready, acc_sel, acc_clr,
        output in_ready, out_valid, out_y, out_op, beat_cnt
    );
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready, acc_sel, acc_clr,
        input  in_ready, out_valid, out_y, out_op, beat_cnt
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_op, beat_cnt
    );
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_op, beat_cnt
    );
`endif
endinterface

// File: rtl/mux_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// mux_logic_unit_pipe
// Two-stage pipelined bitwise logic unit. Every gate function is a per-bit
// 2:1 mux with operand a as the select and b (or a constant) on the data legs.
//   op: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 BUF(a)
// Stage 1 registers a, b, op; stage 2 computes the function and registers
// out_y/out_op. Full throughput with valid/ready back-pressure on both sides.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - mux_logic_unit_pipe_if.slave (handshakes, operands, result,
//            beat_cnt, and acc_sel/acc_clr when the accumulator is built)
// Build option:
//   MUXLU_ACC_EN - adds a WIDTH-bit accumulator holding the last result;
//                  a beat captured with acc_sel=1 uses it in place of b,
//                  acc_clr synchronously clears it (wins over an update).
// -----------------------------------------------------------------------------
module mux_logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_logic_unit_pipe_if.slave  bus
);
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    // Stage 1
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_op_q;
    // Stage 2 / output
    logic             out_valid_q;
    logic [WIDTH-1:0] out_y_q;
    logic [2:0]       out_op_q;
    logic [CNT_W-1:0] beat_cnt_q;

    logic             s2_adv;
    logic             in_ready;
    logic             in_fire;
    logic             s2_load;
    logic             out_fire;
    logic [WIDTH-1:0] d_vec;
    logic [WIDTH-1:0] hi_leg;
    logic [WIDTH-1:0] lo_leg;
    logic [WIDTH-1:0] y_d;

`ifdef MUXLU_ACC_EN
    logic             s1_acc_sel_q;
    logic [WIDTH-1:0] acc_q;
`endif

    // Output stage can take a new value when empty or when it is being consumed;
    // stage 1 can take a beat when empty or when it is moving on.
    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = bus.in_valid && in_ready;
    assign s2_load  = s2_adv && s1_valid_q;
    assign out_fire = out_valid_q && bus.out_ready;

    // NOTE: every variable driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        d_vec  = s1_b_q;
`ifdef MUXLU_ACC_EN
        if (s1_acc_sel_q) d_vec = acc_q;
`endif
        hi_leg = '0;
        lo_leg = '0;
        y_d    = '0;
        // hi_leg is selected where a=1, lo_leg where a=0.
        case (s1_op_q)
            OP_AND:  begin hi_leg = d_vec;  lo_leg = '0;     end
            OP_NAND: begin hi_leg = ~d_vec; lo_leg = '1;     end
            OP_OR:   begin hi_leg = '1;     lo_leg = d_vec;  end
            OP_NOR:  begin hi_leg = '0;     lo_leg = ~d_vec; end
            OP_XOR:  begin hi_leg = ~d_vec; lo_leg = d_vec;  end
            OP_XNOR: begin hi_leg = d_vec;  lo_leg = ~d_vec; end
            OP_NOT:  begin hi_leg = '0;     lo_leg = '1;     end
            OP_BUF:  begin hi_leg = '1;     lo_leg = '0;     end
        endcase
        for (int i = 0; i < WIDTH; i++) begin
            y_d[i] = s1_a_q[i] ? hi_leg[i] : lo_leg[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: datapath registers are reset along with the valids; it costs little
    // and keeps out_y/out_op deterministic after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= bus.in_a;
                s1_b_q     <= bus.in_b;
                s1_op_q    <= bus.in_op;
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_op_q    <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_y_q  <= y_d;
                out_op_q <= s1_op_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else if (out_fire) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
    end

`ifdef MUXLU_ACC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_acc_sel_q <= 1'b0;
        end else if (in_fire) begin
            s1_acc_sel_q <= bus.acc_sel;
        end
    end

    // Clear wins over a same-cycle result update; the beat loading this cycle
    // has already used the old acc value through d_vec.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
        end else if (s2_load) begin
            acc_q <= y_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_op    = out_op_q;
    assign bus.beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mux_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_logic_unit_pipe
// Self-checking bench for mux_logic_unit_pipe (WIDTH=8, CNT_W=4).
// A scoreboard queue holds the expected result of every accepted beat,
// computed with plain boolean operators; outputs are compared in order.
// Define MUXLU_ACC_EN to also exercise the accumulator.
// -----------------------------------------------------------------------------
module tb_mux_logic_unit_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam logic [7:0] SWEEP_Y [8] = '{8'hC0, 8'h3F, 8'hFC, 8'h03,
                                           8'h3C, 8'hC3, 8'h0F, 8'hF0};

    typedef struct {
        logic [7:0] y;
        logic [2:0] op;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    mux_logic_unit_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux_logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_acc   = 0;
    bit         chk_lat = 1'b0;
    bit         last_in_fire = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] prev_y;
    logic [2:0] prev_op;
    logic [7:0] model_acc = '0;
    exp_t       exp_q [$];
    logic [7:0] obs_q [$];

    function automatic logic [7:0] ref_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] d);
        case (op)
            3'd0:    return a & d;
            3'd1:    return ~(a & d);
            3'd2:    return a | d;
            3'd3:    return ~(a | d);
            3'd4:    return a ^ d;
            3'd5:    return ~(a ^ d);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes at the falling edge, update the
    // scoreboard, then advance past the rising edge.
    task automatic step();
        exp_t       e;
        logic [7:0] d;
        @(negedge clk);
        if (stall_prev) begin
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_y", {24'd0, bus.out_y}, {24'd0, prev_y});
            check("hold_op", {29'd0, bus.out_op}, {29'd0, prev_op});
        end
        stall_prev   = bus.out_valid && !bus.out_ready;
        prev_y       = bus.out_y;
        prev_op      = bus.out_op;
        last_in_fire = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_y", {24'd0, bus.out_y}, {24'd0, e.y});
                check("out_op", {29'd0, bus.out_op}, {29'd0, e.op});
                if (chk_lat) check("latency", cyc - e.cyc, 32'd2);
                obs_q.push_back(bus.out_y);
            end
        end
        if (last_in_fire) begin
            d = bus.in_b;
`ifdef MUXLU_ACC_EN
            if (bus.acc_sel) d = model_acc;
`endif
            e.y   = ref_fn(bus.in_op, bus.in_a, d);
            e.op  = bus.in_op;
            e.cyc = cyc;
            model_acc = e.y;
            exp_q.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int waited;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!last_in_fire && waited < 30);
        if (!last_in_fire) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_beat_cnt", {28'd0, bus.beat_cnt}, 32'd0);
        exp_q.delete();
        n_acc      = 0;
        model_acc  = '0;
        stall_prev = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int k;
        logic [7:0] held;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;
`ifdef MUXLU_ACC_EN
        bus.acc_sel   = 1'b0;
        bus.acc_clr   = 1'b0;
`endif

        // Full op sweep, back-to-back, fixed 2-cycle latency.
        do_reset();
        obs_q.delete();
        chk_lat = 1'b1;
        for (int op = 0; op < 8; op++) send(8'hF0, 8'hCC, 3'(op));
        drain();
        chk_lat = 1'b0;
        check("sweep_count", obs_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check($sformatf("sweep_y%0d", i), {24'd0, obs_q[i]}, {24'd0, SWEEP_Y[i]});
        check("sweep_beat_cnt", {28'd0, bus.beat_cnt}, 32'd8);

        // Back-pressure: 5 stalled cycles with beats offered.
        do_reset();
        obs_q.delete();
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'(8'h11 * (k + 1));
            bus.in_b     = 8'h5A;
            bus.in_op    = 3'(k + 2);
            step();
            if (last_in_fire) k++;
            if (c == 2) held = bus.out_y;
        end
        check("bp_accepts", k, 32'd2);
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_out_y_held", {24'd0, bus.out_y}, {24'd0, held});
        check("bp_out_y_val", {24'd0, bus.out_y}, {24'd0, ref_fn(3'd2, 8'h11, 8'h5A)});
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30 && k < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'(8'h11 * (k + 1));
            bus.in_b     = 8'h5A;
            bus.in_op    = 3'(k + 2);
            step();
            if (last_in_fire) k++;
        end
        drain();
        check("bp_out_count", obs_q.size(), 32'd4);
        check("bp_beat_cnt", {28'd0, bus.beat_cnt}, 32'd4);

        // Mid-flight reset: two beats in the pipe are dropped.
        do_reset();
        send(8'hA5, 8'h3C, 3'd4);
        send(8'h0F, 8'hFF, 3'd0);
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check("mfr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mfr_beat_cnt", {28'd0, bus.beat_cnt}, 32'd0);

        // Counter wrap: 17 beats on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) send(8'(i * 13), 8'(i * 7 + 1), 3'(i));
        drain();
        check("wrap_beat_cnt", {28'd0, bus.beat_cnt}, 32'd1);

        // Randomised traffic with random back-pressure.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_a      = 8'($urandom);
            bus.in_b      = 8'($urandom);
            bus.in_op     = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
`ifdef MUXLU_ACC_EN
            bus.acc_sel   = 1'($urandom_range(0, 1));
`endif
            step();
        end
        drain();
        check("rand_beat_cnt", {28'd0, bus.beat_cnt}, 32'(n_acc % 16));

`ifdef MUXLU_ACC_EN
        // Accumulator: clear, OR with b=0F, then XOR against the accumulator.
        do_reset();
        obs_q.delete();
        bus.acc_sel = 1'b0;
        bus.acc_clr = 1'b1;
        step();
        bus.acc_clr = 1'b0;
        model_acc   = '0;
        send(8'h00, 8'h0F, 3'd2);
        bus.acc_sel = 1'b1;
        send(8'hFF, 8'h00, 3'd4);
        bus.acc_sel = 1'b0;
        drain();
        check("acc_count", obs_q.size(), 32'd2);
        if (obs_q.size() == 2) begin
            check("acc_or", {24'd0, obs_q[0]}, 32'h0F);
            check("acc_xor", {24'd0, obs_q[1]}, 32'hF0);
        end

        // Clear priority: acc_clr coincides with the s2 load of a beat.
        obs_q.delete();
        send(8'h00, 8'hAA, 3'd2);
        bus.acc_clr = 1'b1;
        step();
        bus.acc_clr = 1'b0;
        model_acc   = '0;
        bus.acc_sel = 1'b1;
        send(8'h00, 8'h55, 3'd2);
        bus.acc_sel = 1'b0;
        drain();
        check("accclr_count", obs_q.size(), 32'd2);
        if (obs_q.size() == 2) check("accclr_y", {24'd0, obs_q[1]}, 32'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
